// File: rtl/rp_8bit_fetch_tracer.sv
// Fetch-side instruction tracer for the rp8 core: captures accepted program words,
// joins AVR two-word instructions into one 32-bit entry and queues them for a trace consumer.
module rp_8bit_fetch_tracer #(
    parameter int PAW   = 11,
    parameter int DEPTH = 8,
    parameter int CNTW  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PAW-1:0]           pmem_adr,
    input  logic [15:0]              pmem_dat,
    input  logic                     pmem_vld,
    input  logic                     flush,
    output logic                     trc_vld,
    input  logic                     trc_rdy,
    output logic [PAW-1:0]           trc_pc,
    output logic [31:0]              trc_code,
    output logic                     trc_len,
    output logic                     trc_err,
    output logic [$clog2(DEPTH):0]   fifo_cnt,
    output logic [CNTW-1:0]          drop_cnt
);
    localparam int PTRW = $clog2(DEPTH);
    localparam int CW   = PTRW + 1;
    localparam int EW   = PAW + 34;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WAIT2 = 1'b1
    } state_t;

    // LDS/STS: 1001_00??_????_0000, JMP/CALL: 1001_010?_????_11??
    function automatic logic is_two_word(input logic [15:0] w);
        return ((w[15:10] == 6'b100100) && (w[3:0] == 4'b0000)) ||
               ((w[15:9] == 7'b1001010) && (w[3:2] == 2'b11));
    endfunction

    state_t              state_q, state_d;
    logic [PAW-1:0]      pc0_q, pc0_d;
    logic [15:0]         w0_q, w0_d;
    logic [EW-1:0]       mem_q [DEPTH];
    logic [EW-1:0]       mem_d [DEPTH];
    logic [PTRW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CNTW-1:0]     drop_q, drop_d;
    logic [EW-1:0]       head_q, head_d;
    logic                vld_q, vld_d;

    logic                push_s, flush_drop_s, idle_path_s;
    logic [EW-1:0]       entry_s;
    logic                pop_s, full_s, acc_s, ovf_s;
    logic [CNTW:0]       drop_sum_s;

    // Instruction assembly: a flush in WAIT2 discards w0 and lets the current word start afresh.
    always_comb begin
        state_d      = state_q;
        pc0_d        = pc0_q;
        w0_d         = w0_q;
        push_s       = 1'b0;
        entry_s      = '0;
        flush_drop_s = (state_q == WAIT2) && flush;
        idle_path_s  = pmem_vld && ((state_q == IDLE) || flush);
        if (idle_path_s && is_two_word(pmem_dat)) begin
            pc0_d   = pmem_adr;
            w0_d    = pmem_dat;
            state_d = WAIT2;
        end else if (idle_path_s) begin
            push_s  = 1'b1;
            entry_s = {pmem_adr, pmem_dat, 16'h0000, 1'b0, 1'b0};
            state_d = IDLE;
        end else if (pmem_vld) begin
            push_s  = 1'b1;
            entry_s = {pc0_q, w0_q, pmem_dat, 1'b1, (pmem_adr != (pc0_q + PAW'(1)))};
            state_d = IDLE;
        end else if (flush) begin
            state_d = IDLE;
        end else begin
            state_d = state_q;
        end
    end

    // FIFO bookkeeping; the head register is loaded from the post-write array so a push
    // into an empty FIFO becomes visible on the very next cycle.
    always_comb begin
        pop_s      = vld_q && trc_rdy;
        full_s     = (cnt_q == CW'(DEPTH));
        acc_s      = push_s && (!full_s || pop_s);
        ovf_s      = push_s && full_s && !pop_s;
        mem_d      = mem_q;
        mem_d[wr_q] = acc_s ? entry_s : mem_q[wr_q];
        wr_d       = wr_q + PTRW'(acc_s);
        rd_d       = rd_q + PTRW'(pop_s);
        cnt_d      = cnt_q + CW'(acc_s) - CW'(pop_s);
        drop_sum_s = {1'b0, drop_q} + (CNTW+1)'(flush_drop_s) + (CNTW+1)'(ovf_s);
        drop_d     = drop_sum_s[CNTW] ? {CNTW{1'b1}} : drop_sum_s[CNTW-1:0];
        vld_d      = (cnt_d != '0);
        head_d     = vld_d ? mem_d[rd_d] : head_q;
    end

    // State and storage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc0_q   <= '0;
            w0_q    <= '0;
            mem_q   <= '{default: '0};
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            drop_q  <= '0;
            head_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc0_q   <= pc0_d;
            w0_q    <= w0_d;
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
            head_q  <= head_d;
            vld_q   <= vld_d;
        end
    end

    assign trc_vld  = vld_q;
    assign trc_pc   = head_q[EW-1 -: PAW];
    assign trc_code = head_q[33:2];
    assign trc_len  = head_q[1];
    assign trc_err  = head_q[0];
    assign fifo_cnt = cnt_q;
    assign drop_cnt = drop_q;

endmodule
